i2s_clock_gen: RTL and testbench
================================

// Module: i2s_clock_gen
// PURPOSE
// - Parametrised I2S/TDM bit-clock and frame-sync generator, driven from the master audio clock.
// - Generates bclk and lrck/frame-sync, plus 1-cycle mclki-domain strobes and slot/bit indices for the serialiser.
// - Adds configurable frame-sync shape, frame-aligned reconfiguration and graceful stop at frame end.
// PARAMETERS
// DIV_W        8   width of cfg_bclk_half
// WORD_W_MAX   32  max bclk cycles per slot (min legal is 8)
// TDM_MAX      16  max slots per frame
// PORTS
// mclki          in   1      master clock; sole clock
// rst_n          in   1      synchronous reset, active low
// enable         in   1      start/keep running; low = stop at end of current frame
// cfg_bclk_half  in   DIV_W  mclki cycles per bclk half-period
// cfg_word_width in   6      bclk cycles per slot
// cfg_slots      in   5      slots per frame (2 = stereo I2S)
// cfg_fs_mode    in   2      0 = 50% duty, 1 = one-bclk pulse, 2 = one-slot pulse, 3 = same as 0
// cfg_fs_invert  in   1      invert lrck while running
// bclk           out  1      bit clock
// lrck           out  1      frame sync
// bclk_rise      out  1      1-cycle strobe, coincident with bclk 0->1
// bclk_fall      out  1      1-cycle strobe, coincident with bclk 1->0 (data-change edge)
// frame_start    out  1      1-cycle strobe when fbit becomes 0 (incl. RUN entry)
// slot_idx       out  clog2(TDM_MAX)     current slot
// bit_idx        out  clog2(WORD_W_MAX)  bit within slot, 0 = first (MSB) bit
// running        out  1      high in RUN and STOP
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0. Reset overrides everything, including mid-frame.
// - Clamping (shadow load): H = max(cfg_bclk_half,1); W = clamp(cfg_word_width,8,WORD_W_MAX);
//   S = clamp(cfg_slots,1,TDM_MAX). Shadow regs hold H, W, S, mode, invert and F = W*S.
// - Config is loaded into shadow only on IDLE->RUN and at each frame wrap. Mid-frame changes are ignored.
// - States:
//   IDLE: bclk = 0, lrck = 0, no strobes. enable=1 -> RUN, loading shadow that cycle.
//   RUN:  enable=0 -> STOP.
//   STOP: identical timing to RUN. enable=1 -> RUN, with no glitch.
//         At frame wrap: -> IDLE, bclk held 0, lrck = 0, running = 0, no frame_start.
// - RUN entry cycle: half_cnt = 0, bclk = 0, fbit = 0, slot_idx = bit_idx = 0, frame_start = 1.
// - Timing: half_cnt counts 0..H-1. At H-1 it wraps and bclk toggles.
//   bclk period = 2H mclki cycles; first rise H cycles after entry.
// - On each fall, fbit advances; fbit wraps F-1 -> 0. bit_idx/slot_idx are counters (no divider):
//   bit_idx wraps W-1 -> 0 and increments slot_idx. Both reset to 0 at frame wrap.
// - lrck is updated on the fall edge from the new fbit, then XOR invert:
//   mode0: fbit >= F/2 (floor); mode1: fbit == 0; mode2: fbit < W.
//   RUN entry applies the fbit = 0 value immediately.
// - Frame length = F bclk = 2*H*F mclki cycles.
// - Strobes are registered alongside bclk, so bclk_rise/bclk_fall are high on the same cycle bclk changes.
// TESTING
// 1. H=2, W=16, S=2, mode0, inv=0:
//    bclk period 4 mclki; lrck 0 for 16 bclk then 1 for 16;
//    frame_start every 128 mclki; bit_idx 0..15 twice per frame.
// 2. H=1, W=32, S=8, mode1:
//    lrck high exactly 1 bclk per 256 bclk; slot_idx steps 0..7;
//    frame_start aligned with lrck rise.
// 3. Mid-frame change W 16->24 (S=2):
//    current frame stays 32 bclk; next frame 48 bclk; lrck edge at fbit 24.
// 4. enable low at fbit 5 -> frame completes; bclk rests 0, lrck 0, running falls at wrap.
//    enable high again during STOP -> next frame starts seamlessly with frame_start.
// 5. Clamps: cfg_bclk_half=0, word_width=4, slots=0
//    -> bclk period 2 mclki, 8-bclk frame, slot_idx stays 0.
// 6. rst_n low mid-frame, mode2 inv=1 -> next cycle all outputs 0, IDLE;
//    restart gives lrck=0 (inverted) for the first 16 bclk with W=16.

Source files
------------

// File: rtl/i2s_clock_gen.sv
// ---------------------------------------------------------------------------
// i2s_clock_gen
// Parametrised I2S/TDM bit-clock and frame-sync generator. Everything runs in
// the mclki domain: bclk is divided down from mclki, lrck marks the frame, and
// single-cycle strobes plus slot/bit indices let a serialiser stay in step.
//
// Ports
//   mclki          master clock (sole clock)
//   rst_n          synchronous reset, active low
//   enable         run request; dropping it stops cleanly at the end of the frame
//   cfg_bclk_half  mclki cycles per bclk half-period (0 treated as 1)
//   cfg_word_width bclk cycles per slot (clamped to 8..WORD_W_MAX)
//   cfg_slots      slots per frame (clamped to 1..TDM_MAX)
//   cfg_fs_mode    0/3 = 50% duty, 1 = one-bclk pulse, 2 = one-slot pulse
//   cfg_fs_invert  invert lrck while running
//   bclk, lrck     generated bit clock and frame sync
//   bclk_rise      high on the cycle bclk goes 0->1
//   bclk_fall      high on the cycle bclk goes 1->0
//   frame_start    high on the cycle the frame bit counter returns to 0
//   slot_idx       current slot within the frame
//   bit_idx        current bit within the slot, 0 = MSB
//   running        high while a frame is being generated (RUN or STOP)
// ---------------------------------------------------------------------------
module i2s_clock_gen #(
    parameter int DIV_W      = 8,
    parameter int WORD_W_MAX = 32,
    parameter int TDM_MAX    = 16
) (
    input  logic                          mclki,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              cfg_bclk_half,
    input  logic [5:0]                    cfg_word_width,
    input  logic [4:0]                    cfg_slots,
    input  logic [1:0]                    cfg_fs_mode,
    input  logic                          cfg_fs_invert,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          bclk_rise,
    output logic                          bclk_fall,
    output logic                          frame_start,
    output logic [$clog2(TDM_MAX)-1:0]    slot_idx,
    output logic [$clog2(WORD_W_MAX)-1:0] bit_idx,
    output logic                          running
);

    localparam int SLOT_W = $clog2(TDM_MAX);
    localparam int BIT_W  = $clog2(WORD_W_MAX);
    localparam int FW     = $clog2(WORD_W_MAX * TDM_MAX + 1);

    localparam logic [5:0] W_MIN = 6'd8;
    localparam logic [5:0] W_LIM = 6'(WORD_W_MAX);
    localparam logic [4:0] S_LIM = 5'(TDM_MAX);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t state, next_state;

    logic [DIV_W-1:0] h_c, h_q;
    logic [5:0]       w_c, w_q;
    logic [4:0]       s_c;
    logic [FW-1:0]    f_c, f_q;
    logic [1:0]       mode_q;
    logic             inv_q;

    logic [DIV_W-1:0] half_cnt;
    logic [FW-1:0]    fbit;
    logic [FW-1:0]    fbit_inc;
    logic [BIT_W-1:0] last_bit;

    logic tick, fall_evt, wrap, load_cfg;

    // Frame-sync level for a given frame bit position, before and after inversion.
    function automatic logic fs_level(input logic [FW-1:0] fb, input logic [FW-1:0] f,
                                      input logic [5:0] w, input logic [1:0] mode,
                                      input logic inv);
        logic lvl;
        case (mode)
            2'd1:    lvl = (fb == {FW{1'b0}});
            2'd2:    lvl = (fb < FW'(w));
            default: lvl = (fb >= (f >> 1));
        endcase
        return lvl ^ inv;
    endfunction

    // Clamp the live configuration into the legal range; only sampled into the
    // shadow registers at RUN entry and at frame wraps.
    always_comb begin
        h_c = (cfg_bclk_half == {DIV_W{1'b0}}) ? DIV_W'(1) : cfg_bclk_half;
        if (cfg_word_width < W_MIN)      w_c = W_MIN;
        else if (cfg_word_width > W_LIM) w_c = W_LIM;
        else                             w_c = cfg_word_width;
        if (cfg_slots == 5'd0)           s_c = 5'd1;
        else if (cfg_slots > S_LIM)      s_c = S_LIM;
        else                             s_c = cfg_slots;
        f_c = FW'(w_c) * FW'(s_c);
    end

    assign fbit_inc = fbit + FW'(1);
    assign last_bit = BIT_W'(w_q - 6'd1);

    // Next-state logic and the timing events that drive it. A wrap is the fall
    // edge that completes the last bit of the frame.
    always_comb begin
        next_state = state;
        tick       = 1'b0;
        fall_evt   = 1'b0;
        wrap       = 1'b0;
        if (state != IDLE) begin
            tick     = (half_cnt == h_q - DIV_W'(1));
            fall_evt = tick && bclk;
            wrap     = fall_evt && (fbit == f_q - FW'(1));
        end
        case (state)
            IDLE:    if (enable) next_state = RUN;
            RUN:     if (!enable) next_state = STOP;
            STOP: begin
                if (enable)    next_state = RUN;
                else if (wrap) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        load_cfg = ((state == IDLE) && enable) || (wrap && (next_state != IDLE));
    end

    // State register.
    always_ff @(posedge mclki) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Shadow configuration, so that mid-frame changes only land on a frame boundary.
    always_ff @(posedge mclki) begin
        if (!rst_n) begin
            h_q    <= '0;
            w_q    <= '0;
            f_q    <= '0;
            mode_q <= '0;
            inv_q  <= 1'b0;
        end else if (load_cfg) begin
            h_q    <= h_c;
            w_q    <= w_c;
            f_q    <= f_c;
            mode_q <= cfg_fs_mode;
            inv_q  <= cfg_fs_invert;
        end
    end

    // Divider, frame counters and registered outputs. Strobes are produced in
    // the same register stage as bclk so they line up with its edges. The new
    // frame's lrck level uses the freshly loaded configuration.
    always_ff @(posedge mclki) begin
        if (!rst_n) begin
            half_cnt    <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            fbit        <= '0;
            slot_idx    <= '0;
            bit_idx     <= '0;
            running     <= 1'b0;
        end else begin
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            running     <= (next_state != IDLE);
            if (state == IDLE) begin
                half_cnt    <= '0;
                bclk        <= 1'b0;
                fbit        <= '0;
                slot_idx    <= '0;
                bit_idx     <= '0;
                frame_start <= enable;
                lrck        <= enable ? fs_level({FW{1'b0}}, f_c, w_c, cfg_fs_mode, cfg_fs_invert)
                                      : 1'b0;
            end else if (wrap && (next_state == IDLE)) begin
                half_cnt  <= '0;
                bclk      <= 1'b0;
                bclk_fall <= 1'b1;
                fbit      <= '0;
                slot_idx  <= '0;
                bit_idx   <= '0;
                lrck      <= 1'b0;
            end else begin
                if (tick) begin
                    half_cnt  <= '0;
                    bclk      <= ~bclk;
                    bclk_rise <= ~bclk;
                    bclk_fall <= bclk;
                end else begin
                    half_cnt <= half_cnt + DIV_W'(1);
                end
                if (wrap) begin
                    fbit        <= '0;
                    slot_idx    <= '0;
                    bit_idx     <= '0;
                    frame_start <= 1'b1;
                    lrck        <= fs_level({FW{1'b0}}, f_c, w_c, cfg_fs_mode, cfg_fs_invert);
                end else if (fall_evt) begin
                    fbit <= fbit_inc;
                    lrck <= fs_level(fbit_inc, f_q, w_q, mode_q, inv_q);
                    if (bit_idx == last_bit) begin
                        bit_idx  <= '0;
                        slot_idx <= slot_idx + SLOT_W'(1);
                    end else begin
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_i2s_clock_gen
// Self-checking bench for i2s_clock_gen. A reference model tracks the position
// within the current frame in mclki cycles and derives every output from that
// position arithmetically; outputs are compared on every falling mclki edge.
// ---------------------------------------------------------------------------
module tb_i2s_clock_gen;

    localparam int DIV_W      = 8;
    localparam int WORD_W_MAX = 32;
    localparam int TDM_MAX    = 16;

    logic       mclki = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] cfg_bclk_half;
    logic [5:0] cfg_word_width;
    logic [4:0] cfg_slots;
    logic [1:0] cfg_fs_mode;
    logic       cfg_fs_invert;
    logic       bclk, lrck, bclk_rise, bclk_fall, frame_start, running;
    logic [3:0] slot_idx;
    logic [4:0] bit_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = run, 2 = stop; mT = mclki cycles since frame start.
    int mState = 0;
    int mT, mH, mW, mS, mF, mMode, mInv;
    bit mFromIdle;
    logic eBclk, eLrck, eRise, eFall, eFs, eRun;
    int   eSlot, eBit;

    i2s_clock_gen #(
        .DIV_W(DIV_W), .WORD_W_MAX(WORD_W_MAX), .TDM_MAX(TDM_MAX)
    ) dut (
        .mclki(mclki), .rst_n(rst_n), .enable(enable),
        .cfg_bclk_half(cfg_bclk_half), .cfg_word_width(cfg_word_width),
        .cfg_slots(cfg_slots), .cfg_fs_mode(cfg_fs_mode), .cfg_fs_invert(cfg_fs_invert),
        .bclk(bclk), .lrck(lrck), .bclk_rise(bclk_rise), .bclk_fall(bclk_fall),
        .frame_start(frame_start), .slot_idx(slot_idx), .bit_idx(bit_idx),
        .running(running)
    );

    always #5 mclki = ~mclki;

    function automatic bit fsRule(int fb, int f, int w, int mode);
        case (mode)
            1:       return fb == 0;
            2:       return fb < w;
            default: return fb >= f / 2;
        endcase
    endfunction

    task automatic loadCfg();
        mH    = (cfg_bclk_half == 0) ? 1 : int'(cfg_bclk_half);
        mW    = (cfg_word_width < 8) ? 8 : (cfg_word_width > WORD_W_MAX ? WORD_W_MAX : int'(cfg_word_width));
        mS    = (cfg_slots < 1) ? 1 : (cfg_slots > TDM_MAX ? TDM_MAX : int'(cfg_slots));
        mF    = mW * mS;
        mMode = int'(cfg_fs_mode);
        mInv  = int'(cfg_fs_invert);
    endtask

    task automatic idleOutputs(input bit fallStrobe);
        eBclk = 0; eLrck = 0; eRise = 0; eFall = fallStrobe; eFs = 0; eRun = 0;
        eSlot = 0; eBit = 0;
    endtask

    task automatic frameOutputs();
        int halfIdx, ph, fb;
        halfIdx = mT / mH;
        ph      = mT % mH;
        fb      = halfIdx / 2;
        eBclk   = (halfIdx % 2) == 1;
        eRise   = (ph == 0) && (halfIdx % 2 == 1);
        eFall   = (ph == 0) && (halfIdx % 2 == 0) && !(mT == 0 && mFromIdle);
        eFs     = (mT == 0);
        eSlot   = fb / mW;
        eBit    = fb % mW;
        eLrck   = fsRule(fb, mF, mW, mMode) ^ mInv[0];
        eRun    = 1;
    endtask

    // Advance the model by one mclki edge using the inputs the DUT sampled.
    task automatic modelStep();
        int  nxt;
        bit  frameEnd;
        if (!rst_n) begin
            mState = 0;
            idleOutputs(1'b0);
        end else if (mState == 0) begin
            if (enable) begin
                mState = 1; loadCfg(); mT = 0; mFromIdle = 1; frameOutputs();
            end else begin
                idleOutputs(1'b0);
            end
        end else begin
            frameEnd = (mT == 2 * mH * mF - 1);
            nxt = mState;
            if (mState == 1 && !enable) nxt = 2;
            else if (mState == 2)       nxt = enable ? 1 : (frameEnd ? 0 : 2);
            mState = nxt;
            if (nxt == 0) begin
                idleOutputs(1'b1);
            end else begin
                if (frameEnd) begin mT = 0; loadCfg(); mFromIdle = 0; end
                else mT++;
                frameOutputs();
            end
        end
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("bclk",        32'(bclk),        32'(eBclk));
        checkOne("lrck",        32'(lrck),        32'(eLrck));
        checkOne("bclk_rise",   32'(bclk_rise),   32'(eRise));
        checkOne("bclk_fall",   32'(bclk_fall),   32'(eFall));
        checkOne("frame_start", 32'(frame_start), 32'(eFs));
        checkOne("running",     32'(running),     32'(eRun));
        checkOne("slot_idx",    32'(slot_idx),    32'(eSlot));
        checkOne("bit_idx",     32'(bit_idx),     32'(eBit));
    endtask

    // Run n mclki cycles; inputs change only between calls, i.e. after a falling edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge mclki);
            modelStep();
            @(negedge mclki);
            checkOutput();
        end
    endtask

    task automatic setCfg(input int h, input int w, input int s, input int mode, input int inv);
        cfg_bclk_half  = 8'(h);
        cfg_word_width = 6'(w);
        cfg_slots      = 5'(s);
        cfg_fs_mode    = 2'(mode);
        cfg_fs_invert  = inv[0];
    endtask

    task automatic restart();
        rst_n = 1'b0;
        applyStimulus(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        setCfg(2, 16, 2, 0, 0);
        applyStimulus(3);
        rst_n = 1'b1;
        applyStimulus(3);

        $display("[TB] stereo I2S, 50%% duty");
        enable = 1'b1;
        applyStimulus(300);

        $display("[TB] 8-slot TDM, one-bclk pulse");
        setCfg(1, 32, 8, 1, 0);
        restart();
        applyStimulus(1100);

        $display("[TB] mid-frame word width change");
        setCfg(1, 16, 2, 0, 0);
        restart();
        applyStimulus(10);
        cfg_word_width = 6'd24;
        applyStimulus(220);

        $display("[TB] graceful stop and resume");
        setCfg(2, 16, 2, 0, 0);
        restart();
        applyStimulus(21);
        enable = 1'b0;
        applyStimulus(150);
        enable = 1'b1;
        applyStimulus(140);
        enable = 1'b0;
        applyStimulus(30);
        enable = 1'b1;
        applyStimulus(130);
        enable = 1'b0;
        applyStimulus(260);

        $display("[TB] configuration clamps");
        setCfg(0, 4, 0, 0, 0);
        enable = 1'b1;
        applyStimulus(40);
        setCfg(3, 63, 31, 3, 1);
        applyStimulus(40);

        $display("[TB] reset mid-frame, one-slot pulse inverted");
        setCfg(1, 16, 2, 2, 1);
        restart();
        applyStimulus(30);
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(80);

        $display("[TB] randomized configurations");
        for (int r = 0; r < 8; r++) begin
            setCfg($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 6),
                   $urandom_range(0, 3), $urandom_range(0, 1));
            enable = 1'b1;
            for (int c = 0; c < 6; c++) begin
                if ($urandom_range(0, 3) == 0) enable = ~enable;
                if ($urandom_range(0, 2) == 0)
                    setCfg($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 6),
                           $urandom_range(0, 3), $urandom_range(0, 1));
                applyStimulus($urandom_range(20, 300));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
